// File: rtl/evenzeroes_seq_ctrl_pkg.sv
// Shared types and defaults for the even-zeroes checker sequencer.
package evenzeroes_ctrl_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_SPACER = 1;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    SPACE,
    RESULT
  } state_t;

  // A dual-rail value is valid only when exactly one rail is high.
  function automatic logic dr_valid(input logic p1, input logic p0);
    return p1 ^ p0;
  endfunction

endpackage

// File: rtl/evenzeroes_seq_ctrl_if.sv
// Bundle of the requester handshake, checker rails and result handshake.
interface evenzeroes_seq_ctrl_if #(
  parameter int WIDTH = evenzeroes_ctrl_pkg::DEF_WIDTH,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             bit1;
  logic             bit0;
  logic             parity1;
  logic             parity0;
  logic             res_valid;
  logic             res_ready;
  logic             res_parity;
  logic             res_err;
  logic             busy;

  // Controller side.
  modport slave (
    input  in_valid, in_data, in_len, parity1, parity0, res_ready,
    output in_ready, bit1, bit0, res_valid, res_parity, res_err, busy
  );

  // Producer / checker / consumer side.
  modport master (
    output in_valid, in_data, in_len, parity1, parity0, res_ready,
    input  in_ready, bit1, bit0, res_valid, res_parity, res_err, busy
  );
endinterface

// File: rtl/evenzeroes_seq_ctrl_phase_timer.sv
// Loadable down-counter with a zero flag; times the settle and spacer phases.
module evenzeroes_phase_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);
  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Load wins over decrement; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/evenzeroes_seq_ctrl.sv
// Serializes words LSB-first onto the dual-rail checker inputs with a
// return-to-spacer between bits, and reports the sampled parity per word.
module evenzeroes_seq_ctrl
  import evenzeroes_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LEN_W  = $clog2(WIDTH + 1),
  parameter int SETTLE = DEF_SETTLE,
  parameter int SPACER = DEF_SPACER
) (
  input logic                   clk,
  input logic                   rst,
  evenzeroes_seq_ctrl_if.slave  bus
);
  localparam int TMAX = (SETTLE > SPACER) ? SETTLE : SPACER;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]    SETTLE_M1 = TW'(SETTLE - 1);
  localparam logic [TW-1:0]    SPACER_M1 = TW'(SPACER - 1);
  localparam logic [LEN_W-1:0] WIDTH_L   = LEN_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             par_q, par_d;
  logic             err_q, err_d;
  logic             bit1_q, bit1_d;
  logic             bit0_q, bit0_d;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             len_ok;
  logic             drive_d;

  evenzeroes_phase_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign len_ok = (bus.in_len != '0) && (bus.in_len <= WIDTH_L);

  // Next-state, datapath updates and registered-rail targets.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    par_d    = par_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          rem_d   = bus.in_len;
          par_d   = 1'b0;
          err_d   = 1'b0;
          if (len_ok) begin
            state_d  = DRIVE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_M1;
          end else begin
            // Unsendable length: report an error without touching the rails.
            state_d = RESULT;
            err_d   = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        par_d = bus.parity1;
        if (!dr_valid(bus.parity1, bus.parity0)) begin
          err_d = 1'b1;
        end
        state_d  = SPACE;
        tmr_load = 1'b1;
        tmr_val  = SPACER_M1;
      end
      SPACE: begin
        if (tmr_zero) begin
          shreg_d = shreg_q >> 1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = RESULT;
          end else begin
            state_d  = DRIVE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_M1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Rails are registered so they follow the state exactly and never glitch
    // into the asynchronous checker; both are low outside DRIVE/SAMPLE.
    drive_d = (state_d == DRIVE) || (state_d == SAMPLE);
    bit1_d  = drive_d & shreg_d[0];
    bit0_d  = drive_d & ~shreg_d[0];
  end

  // State and datapath registers; reset drops the word and the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
      bit1_q  <= 1'b0;
      bit0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      par_q   <= par_d;
      err_q   <= err_d;
      bit1_q  <= bit1_d;
      bit0_q  <= bit0_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE) && !rst;
  assign bus.bit1       = bit1_q;
  assign bus.bit0       = bit0_q;
  assign bus.res_valid  = (state_q == RESULT);
  assign bus.res_parity = par_q;
  assign bus.res_err    = err_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_evenzeroes_seq_ctrl.sv
// Directed bench for the even-zeroes checker sequencer.
module tb_evenzeroes_seq_ctrl;
  localparam int WIDTH  = 8;
  localparam int LEN_W  = 4;
  localparam int SETTLE = 2;
  localparam int SPACER = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  evenzeroes_seq_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus_if ();

  evenzeroes_seq_ctrl #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .SETTLE(SETTLE), .SPACER(SPACER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one word, watch the rails cycle by cycle, then consume the result.
  task automatic run_word(input string name, input logic [7:0] data, input logic [3:0] len,
                          input int bad, input int exp_cyc, input int exp_nb,
                          input logic [7:0] exp_seq, input logic exp_par, input logic exp_err,
                          input int hold, input bit early);
    int run, zrun, nb, cyc;
    logic cur, both_hi, bad_hold, bad_sp, seen, unstable, ir_bad, busy_bad;
    logic [7:0] seq;
    run = 0; zrun = 0; nb = 0; cyc = 0; cur = 1'b0; seq = '0;
    both_hi = 0; bad_hold = 0; bad_sp = 0; seen = 0; unstable = 0; ir_bad = 0; busy_bad = 0;
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    bus_if.res_ready = early;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = data;
    bus_if.in_len    = len;
    @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == bad) begin
        bus_if.parity1 = 1'b0; bus_if.parity0 = 1'b0;
      end else begin
        bus_if.parity1 = 1'b1; bus_if.parity0 = 1'b0;
      end
      if (bus_if.bit1 & bus_if.bit0) both_hi = 1'b1;
      if (bus_if.bit1 | bus_if.bit0) begin
        if (run == 0) begin
          if (nb > 0 && zrun != SPACER) bad_sp = 1'b1;
          if (nb < 8) seq[nb] = bus_if.bit1;
          cur = bus_if.bit1;
          nb++;
        end
        if (bus_if.bit1 != cur) bad_hold = 1'b1;
        run++;
      end else begin
        if (run != 0) begin
          if (run != SETTLE + 1) bad_hold = 1'b1;
          run = 0;
          zrun = 1;
        end else begin
          zrun++;
        end
      end
      if (bus_if.res_valid) begin
        seen = 1'b1;
        cyc = n;
        break;
      end
    end
    bus_if.parity1 = 1'b1; bus_if.parity0 = 1'b0;
    if (!seen) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      bus_if.res_ready = 1'b1;
      @(negedge clk);
      bus_if.res_ready = 1'b0;
      return;
    end
    $display("%s: data=%02h len=%0d result after %0d cycles, bits=%0d seq=%02h parity=%0b err=%0b",
             name, data, len, cyc, nb, seq, bus_if.res_parity, bus_if.res_err);
    chk({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({name, "_nbits"}, 32'(nb), 32'(exp_nb));
    chk({name, "_seq"}, 32'(seq), 32'(exp_seq));
    chk({name, "_parity"}, 32'(bus_if.res_parity), 32'(exp_par));
    chk({name, "_err"}, 32'(bus_if.res_err), 32'(exp_err));
    chk({name, "_rails_excl"}, 32'(both_hi), 32'd0);
    chk({name, "_hold"}, 32'(bad_hold), 32'd0);
    chk({name, "_spacer"}, 32'(bad_sp), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus_if.res_valid !== 1'b1 || bus_if.res_parity !== exp_par || bus_if.res_err !== exp_err)
        unstable = 1'b1;
      if (bus_if.in_ready !== 1'b0) ir_bad = 1'b1;
      if (bus_if.busy !== 1'b1) busy_bad = 1'b1;
    end
    if (hold > 0) begin
      chk({name, "_stable"}, 32'(unstable), 32'd0);
      chk({name, "_no_overlap"}, 32'(ir_bad), 32'd0);
      chk({name, "_busy_hold"}, 32'(busy_bad), 32'd0);
    end
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    chk({name, "_idle_ready"}, 32'(bus_if.in_ready), 32'd1);
    chk({name, "_idle_valid"}, 32'(bus_if.res_valid), 32'd0);
    chk({name, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
    bus_if.res_ready = 1'b0;
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_len    = '0;
    bus_if.res_ready = 1'b0;
    bus_if.parity1   = 1'b1;
    bus_if.parity0   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("rst_rails", 32'({bus_if.bit1, bus_if.bit0}), 32'd0);
    chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    chk("rst_res_parity", 32'(bus_if.res_parity), 32'd0);
    chk("rst_res_err", 32'(bus_if.res_err), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus_if.in_ready), 32'd1);

    //        name      data   len  bad cyc nb  seq    par   err   hold early
    run_word("a5_full", 8'hA5, 4'd8, 0, 33, 8, 8'hA5, 1'b1, 1'b0, 0, 1'b0);
    run_word("a5_perr", 8'hA5, 4'd8, 11, 33, 8, 8'hA5, 1'b1, 1'b1, 0, 1'b0);
    run_word("len3",    8'h06, 4'd3, 0, 13, 3, 8'h06, 1'b1, 1'b0, 5, 1'b0);
    run_word("len0",    8'hFF, 4'd0, 0, 1,  0, 8'h00, 1'b0, 1'b1, 0, 1'b1);
    run_word("len9",    8'hFF, 4'd9, 0, 1,  0, 8'h00, 1'b0, 1'b1, 0, 1'b0);

    // Reset in the middle of bit 4 (cycles 17-18 drive it, 19 samples).
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'hA5;
    bus_if.in_len   = 4'd8;
    @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_bit4_rails", 32'({bus_if.bit1, bus_if.bit0}), 32'b01);
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-word: rails=%0b%0b valid=%0b busy=%0b",
             bus_if.bit1, bus_if.bit0, bus_if.res_valid, bus_if.busy);
    chk("mid_rst_rails", 32'({bus_if.bit1, bus_if.bit0}), 32'd0);
    chk("mid_rst_valid", 32'(bus_if.res_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    run_word("post_rst", 8'h3C, 4'd8, 0, 33, 8, 8'h3C, 1'b1, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/evenzeroes_seq_ctrl.md
Name: evenzeroes_seq_ctrl

Overview:
Clocked sequencer that feeds the dual-rail even-zeroes parity checker. Accepts words from a valid/ready requester and serializes them LSB-first onto the checker's dual-rail inputs (bit1/bit0), using return-to-spacer between bits. Samples the checker's dual-rail parity outputs after each bit and returns one result per word. Sits between a synchronous producer and the asynchronous checker; it is the only driver of the checker inputs.

Parameters:
WIDTH, 8, maximum word length in bits.
LEN_W, $clog2(WIDTH+1), width of the length field.
SETTLE, 2, cycles a data rail is held before sampling (>=1).
SPACER, 1, cycles both rails are held low between bits (>=1).

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  word offered.
in_ready  output  1  controller accepts a word this cycle.
in_data  input  WIDTH  word; bit 0 is sent first.
in_len  input  LEN_W  number of bits to send (1..WIDTH).
bit1  output  1  checker true rail.
bit0  output  1  checker false rail.
parity1  input  1  checker parity true rail.
parity0  input  1  checker parity false rail.
res_valid  output  1  result available.
res_ready  input  1  consumer takes result.
res_parity  output  1  parity1 value sampled after the last bit.
res_err  output  1  protocol error seen during the word.
busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values: in_ready=0 during reset, then 1 in IDLE. bit1=0, bit0=0, res_valid=0, res_parity=0, res_err=0, busy=0. State=IDLE. Shift register, counters and error flag are cleared.
- Reset mid-word: rails return to spacer (0,0) at the next edge. The word and any pending result are discarded.
- States: IDLE, DRIVE, SAMPLE, SPACE, RESULT.
- IDLE: in_ready=1 and both rails are 0.
  - On in_valid&in_ready, latch in_data and in_len, and clear the error flag.
  - If 1<=in_len<=WIDTH, go to DRIVE.
  - Otherwise (in_len=0 or in_len>WIDTH), go to RESULT with res_err=1 and res_parity=0. No rails are driven.
- DRIVE: drive bit1=shreg[0], bit0=~shreg[0] for SETTLE cycles, then go to SAMPLE.
- SAMPLE: one cycle; rails are still driven.
  - Capture parity1 into the result register.
  - Set err if (parity1 ~^ parity0), i.e. the parity rails are not one-hot.
  - Go to SPACE.
- SPACE: bit1=bit0=0 for SPACER cycles. On exit, shift shreg right by 1 and decrement the remaining count.
  - Remaining = 0: go to RESULT.
  - Otherwise: go to DRIVE.
- Rail invariant: bit1&bit0 is never 1 in any cycle. Data rails never change directly from one data value to another without a spacer in between.
- Per-bit cost: SETTLE+1+SPACER cycles.
  - A word of length L enters RESULT L*(SETTLE+1+SPACER) cycles after the first DRIVE cycle.
  - The first DRIVE cycle is the cycle after acceptance.
- RESULT: res_valid=1, and res_parity/res_err are stable while res_valid=1.
  - On res_ready, go to IDLE next cycle. in_ready is 0 until then (no overlap).
  - res_ready may already be high on entry; the result is then consumed in one cycle.
- Checker state is cumulative across words. The controller never resets the checker; res_parity reflects the checker's state after the last bit.
- Inputs parity1/parity0 are sampled only in SAMPLE and ignored in all other states.

Decomposition:
- Package evenzeroes_ctrl_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, SPACE, RESULT);
  - the default WIDTH, SETTLE and SPACER constants;
  - function dr_valid(p1,p0), returning p1^p0.
- Natural sub-module: evenzeroes_phase_timer.
  - Loadable down-counter with a zero flag.
  - Reused for the SETTLE and SPACER intervals.
  - The top level holds the FSM, shift register, bit counter and result registers.

Test Plan:
- WIDTH=8, SETTLE=2, SPACER=1. Accept in_data=8'hA5, in_len=8. Stub holds parity1=1, parity0=0.
  -> Data-rail sequence 1,0,1,0,0,1,0,1, each held 3 cycles and followed by 1 spacer cycle.
  -> res_valid rises 33 cycles after the accept edge, with res_parity=1 and res_err=0.
- Same word; stub drives parity rails (0,0) during the 3rd SAMPLE only.
  -> res_err=1, res_parity=1.
  -> All 8 bits are still sent.
- in_len=3, in_data=8'h06.
  -> Rails carry 0,1,1 only.
  -> res_valid rises 13 cycles after the accept edge.
- in_len=0, then separately in_len=9.
  -> No rail activity; res_valid=1 on the cycle after accept with res_err=1 and res_parity=0.
- res_ready held low 5 cycles in RESULT.
  -> res_valid, res_parity and res_err stay stable.
  -> in_ready=0 and busy=1 throughout.
  -> IDLE one cycle after res_ready=1.
- Assert rst during the DRIVE of bit 4.
  -> Next cycle: bit1=bit0=0, res_valid=0, busy=0, in_ready=1 after rst deasserts.
  -> A new word is then processed from bit 0.
  -> Every test also asserts that bit1&bit0 is never 1.
